// File: rtl/femto_loader.sv
// femto_loader: buffers host instructions and shifts them onto the femto io bus as mode/fill frames.
// Build option LOADER_AUTORUN_EN: close with RUN and park with a free-running target clock.
module femto_loader #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned AW     = 3,
  parameter int unsigned CLKDIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [6:0]    wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] count,
  output logic [7:0]    io_out
);

  localparam int unsigned   FRAME   = 2 * CLKDIV;
  localparam int unsigned   PW      = (FRAME > 2) ? $clog2(FRAME) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(FRAME - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLKDIV);
  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH);
  localparam logic [6:0]    PL_IDLE = 7'h00;
  localparam logic [6:0]    PL_FILL = 7'h50;
`ifdef LOADER_AUTORUN_EN
  localparam logic [6:0]    PL_END  = 7'h48;
`else
  localparam logic [6:0]    PL_END  = 7'h40;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DATA,
`ifdef LOADER_AUTORUN_EN
    S_RUN,
`endif
    S_END
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [6:0]    buf_q [DEPTH];
`ifdef LOADER_AUTORUN_EN
  logic          restart_q, restart_d;
`endif

  logic          frame_end, accept, legal, start_ok;
  logic          wr_ready_d, busy_d, done_d, err_d;
  logic [AW-1:0] count_d;
  logic [7:0]    io_d;
  logic [6:0]    payload;

  assign frame_end = (phase_q == PH_LAST);
  assign accept    = wr_valid && wr_ready;
  assign legal     = (wr_data[2:0] != 3'b000) && (wr_data[6:5] != 2'b10);
`ifdef LOADER_AUTORUN_EN
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_RUN));
`else
  assign start_ok  = start && (state_q == S_IDLE);
`endif

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
`ifdef LOADER_AUTORUN_EN
      restart_q <= 1'b0;
`endif
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      io_out    <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
`ifdef LOADER_AUTORUN_EN
      restart_q <= restart_d;
`endif
      wr_ready  <= wr_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      count     <= count_d;
      io_out    <= io_d;
    end
  end

  // Instruction storage; write pointer is the current count
  always_ff @(posedge clk) begin
    if (accept && legal) buf_q[count] <= wr_data;
  end

  // Next-state: frames advance only at frame boundaries
  always_comb begin
    state_d   = state_q;
    phase_d   = frame_end ? '0 : phase_q + 1'b1;
    idx_d     = idx_q;
`ifdef LOADER_AUTORUN_EN
    restart_d = restart_q;
`endif
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        idx_d = '0;
        if (frame_end) state_d = (count == '0) ? S_END : S_DATA;
      end
      S_DATA: begin
        if (frame_end) begin
          if (idx_q == count - 1'b1) state_d = S_END;
          else                       idx_d   = idx_q + 1'b1;
        end
      end
      S_END: begin
        if (frame_end) begin
          idx_d = '0;
`ifdef LOADER_AUTORUN_EN
          state_d = S_RUN;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef LOADER_AUTORUN_EN
      // A start in RUN is held until the current frame completes
      S_RUN: begin
        if (start) restart_d = 1'b1;
        if (frame_end && (restart_q || start)) begin
          state_d   = S_FILL;
          restart_d = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: computed from next-state so every output is a plain register
  always_comb begin
    payload = PL_IDLE;
    case (state_d)
      S_FILL:  payload = PL_FILL;
      S_DATA:  payload = buf_q[idx_d];
      S_END:   payload = PL_END;
      default: payload = PL_IDLE;
    endcase
    io_d   = {payload, (state_d != S_IDLE) && (phase_d >= PH_RISE)};
    busy_d = (state_d == S_FILL) || (state_d == S_DATA) || (state_d == S_END);
    done_d = (state_q == S_END) && frame_end;

    count_d = count;
    if (accept && legal) count_d = count + 1'b1;
    if (done_d)          count_d = '0;

    err_d = err;
    if (start_ok)         err_d = 1'b0;
    if (accept && !legal) err_d = 1'b1;

`ifdef LOADER_AUTORUN_EN
    wr_ready_d = ((state_d == S_IDLE) || (state_d == S_RUN)) && (count_d < CNT_MAX);
`else
    wr_ready_d = (state_d == S_IDLE) && (count_d < CNT_MAX);
`endif
  end

endmodule

// File: tb/tb_femto_loader.sv
// tb_femto_loader: randomized directed-step bench; expected io frames are built from a word-queue model.
module tb_femto_loader;

  localparam int unsigned DEPTH  = 6;
  localparam int unsigned AW     = 3;
  localparam int unsigned CLKDIV = 2;
  localparam int unsigned FRAME  = 2 * CLKDIV;
`ifdef LOADER_AUTORUN_EN
  localparam logic [6:0]  END_PL = 7'h48;
`else
  localparam logic [6:0]  END_PL = 7'h40;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_valid = 1'b0;
  logic          start    = 1'b0;
  logic [6:0]    wr_data  = 7'h00;
  logic          wr_ready, busy, done, err;
  logic [AW-1:0] count;
  logic [7:0]    io_out;

  int checks = 0;
  int errors = 0;

  logic [6:0] model_q [$];
  logic [7:0] exp_q   [$];
  bit         model_err = 1'b0;

  always #5 clk = ~clk;

  femto_loader #(.DEPTH(DEPTH), .AW(AW), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
    .count(count), .io_out(io_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic bit is_legal(input logic [6:0] w);
    return (w[2:0] != 3'b000) && (w[6:5] != 2'b10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [6:0] p);
    for (int i = 0; i < int'(FRAME); i++)
      exp_q.push_back({p, (i >= int'(CLKDIV)) ? 1'b1 : 1'b0});
  endtask

  // Called at a negedge; leaves at the negedge after the word has been taken
  task automatic write_word(input logic [6:0] w);
    int n;
    n = 0;
    wr_data  = w;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    if (n < 20) begin
      if (is_legal(w)) model_q.push_back(w);
      else             model_err = 1'b1;
    end
    check("count", 32'(count), 32'(model_q.size()));
    check("err", 32'(err), 32'(model_err));
  endtask

  // Pulses start and checks every io byte; exact>=0 demands that many RUN cycles before FILL
  task automatic run_load(input int glitch, input int exact);
    int n;
    exp_q.delete();
    add_frame(7'h50);
    foreach (model_q[i]) add_frame(model_q[i]);
    add_frame(END_PL);
    model_err = 1'b0;
    start = 1'b1;
    for (n = 0; n <= int'(FRAME); n++) begin
      @(negedge clk);
      start = 1'b0;
      if (io_out === 8'hA0) break;
      check("run_payload", 32'(io_out[7:1]), 32'd0);
    end
    if (exact >= 0) check("fill_align", 32'(n), 32'(exact));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        @(negedge clk);
        start = (k == glitch);
      end
      check("io_seq", 32'(io_out), 32'(exp_q[k]));
      check("busy", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("count_clr", 32'(count), 32'd0);
    check("err_clr", 32'(err), 32'd0);
    check("io_after", 32'(io_out), 32'd0);
    model_q.delete();
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n, it, g;
`ifdef LOADER_AUTORUN_EN
    int rph, r;
`endif
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_io", 32'(io_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(wr_ready), 32'd1);

    // Asynchronous reset while the target clock is high in a DATA frame
    write_word(7'h0F);
    write_word(7'h2B);
    start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_io", 32'(io_out), 32'h1F);
    #2 rst_n = 1'b0;
    #1;
    check("arst_io", 32'(io_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    model_q.delete();
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_recover", 32'(wr_ready), 32'd1);

    // Two legal words: A0 A0 A1 A1 1E 1E 1F 1F 56 56 57 57 then closing command
    write_word(7'h0F);
    write_word(7'h2B);
    run_load(-1, -1);

    // Illegal words are handshaken, dropped, and flag err; empty load follows
    write_word(7'h08);
    write_word(7'h47);
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_err", 32'(err), 32'd1);
    run_load(-1, -1);

    // Fill to DEPTH, hold off an extra write, stray start during DATA
    it = 0;
    while (model_q.size() < int'(DEPTH) && it < 200) begin
      write_word(7'($urandom));
      it++;
    end
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_ready", 32'(wr_ready), 32'd0);
    wr_data  = 7'h11;
    wr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("held_ready", 32'(wr_ready), 32'd0);
      check("held_count", 32'(count), 32'(DEPTH));
    end
    wr_valid = 1'b0;
    run_load(3 * int'(FRAME) + 1, -1);

    // Random rounds
    for (int rnd = 0; rnd < 4; rnd++) begin
      n  = int'($urandom_range(0, DEPTH));
      it = 0;
      while (model_q.size() < n && it < 200) begin
        write_word(7'($urandom));
        it++;
      end
      g = (n > 0) ? int'($urandom_range(FRAME, FRAME * (n + 1) - 1)) : -1;
      run_load(g, -1);
    end

`ifdef LOADER_AUTORUN_EN
    // Free-running clock in RUN; a write then a start lands on the next frame boundary
    rph = 1;
    r   = int'($urandom_range(2, 9));
    for (int i = 0; i < r; i++) begin
      @(negedge clk);
      rph = (rph + 1) % int'(FRAME);
      check("run_clk", 32'(io_out), (rph >= int'(CLKDIV)) ? 32'd1 : 32'd0);
      check("run_busy", 32'(busy), 32'd0);
      if (i == 0) begin
        wr_data  = 7'h17;
        wr_valid = 1'b1;
      end
      if (i == 1) begin
        wr_valid = 1'b0;
        model_q.push_back(7'h17);
      end
    end
    check("run_count", 32'(count), 32'd1);
    run_load(-1, int'(FRAME) - 1 - rph);
`else
    repeat (3) begin
      @(negedge clk);
      check("idle_io", 32'(io_out), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
